// File: rtl/simd_sat_addsub.sv
// simd_sat_addsub: pipelined partitioned add/sub with run-time lane grouping and two-sided signed saturation
module simd_sat_addsub #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic                      sub,
    input  logic                      sat_en,
    input  logic [1:0]                mode,
    input  logic                      clr_sticky,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          sum,
    output logic [WIDTH/LANE_W-1:0]   ovfl,
    output logic [WIDTH/LANE_W-1:0]   sat_sticky
);
    localparam int NLANE = WIDTH / LANE_W;
    logic [WIDTH-1:0]  bx, res;
    logic [NLANE-1:0]  ms, nxt_ovfl;
    logic [LANE_W:0]   t;
    logic              st, cy, gov, gneg, xfer;
    assign in_ready = !rst && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    always_comb begin
        bx       = sub ? ~b : b;
        res      = '0;
        ms       = '0;
        nxt_ovfl = '0;
        t        = '0;
        st       = 1'b0;
        cy       = 1'b0;
        gov      = 1'b0;
        gneg     = 1'b0;
        for (int i = 0; i < NLANE; i++) begin
            st    = mode == 2'b00 || (mode == 2'b01 && i % 2 == 0) || (mode == 2'b10 && i % 4 == 0) || i == 0;
            ms[i] = mode == 2'b00 || (mode == 2'b01 && i % 2 == 1) || (mode == 2'b10 && i % 4 == 3) || i == NLANE-1;
            t = {1'b0, a[i*LANE_W +: LANE_W]} + {1'b0, bx[i*LANE_W +: LANE_W]} + {{LANE_W{1'b0}}, st ? sub : cy};
            cy = t[LANE_W];
            res[i*LANE_W +: LANE_W] = t[LANE_W-1:0];
            nxt_ovfl[i] = ms[i] && a[i*LANE_W+LANE_W-1] == bx[i*LANE_W+LANE_W-1] && t[LANE_W-1] != a[i*LANE_W+LANE_W-1];
        end
        // Walk down from each group's MS lane so every lane sees its group's overflow direction
        for (int i = NLANE-1; i >= 0; i--) begin
            gov  = ms[i] ? nxt_ovfl[i] : gov;
            gneg = ms[i] ? a[i*LANE_W+LANE_W-1] : gneg;
            res[i*LANE_W +: LANE_W] = !(sat_en && gov) ? res[i*LANE_W +: LANE_W] :
                                      ms[i] ? {gneg, {(LANE_W-1){~gneg}}} : {LANE_W{~gneg}};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            sum        <= '0;
            ovfl       <= '0;
            sat_sticky <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            sum        <= res;
            ovfl       <= nxt_ovfl;
            sat_sticky <= (clr_sticky ? '0 : sat_sticky) | nxt_ovfl;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (clr_sticky)
                sat_sticky <= '0;
        end
    end
endmodule

// File: tb/tb_simd_sat_addsub.sv
// tb_simd_sat_addsub: directed vector table plus handshake, sticky and reset sequences
module tb_simd_sat_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] a = '0, b = '0, sum;
    logic        sub = 1'b0, sat_en = 1'b0, clr_sticky = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        out_valid, out_ready = 1'b0;
    logic [3:0]  ovfl, sat_sticky;
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        logic [1:0]  mode;
        logic        sub;
        logic        sat;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic [3:0]  o;
    } vec_t;
    vec_t tv[12];

    simd_sat_addsub #(.WIDTH(16), .LANE_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat_en(sat_en), .mode(mode), .clr_sticky(clr_sticky),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovfl(ovfl), .sat_sticky(sat_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        mode   = v.mode;
        sub    = v.sub;
        sat_en = v.sat;
        a      = v.a;
        b      = v.b;
    endtask

    initial begin
        tv[0]  = '{2'b00, 1'b0, 1'b1, 16'h7181, 16'h1181, 16'h7282, 4'b1010};
        tv[1]  = '{2'b00, 1'b0, 1'b0, 16'h7181, 16'h1181, 16'h8202, 4'b1010};
        tv[2]  = '{2'b01, 1'b1, 1'b1, 16'h807F, 16'h0180, 16'h807F, 4'b1010};
        tv[3]  = '{2'b01, 1'b0, 1'b1, 16'h1234, 16'h0101, 16'h1335, 4'b0000};
        tv[4]  = '{2'b10, 1'b0, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b1000};
        tv[5]  = '{2'b11, 1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 4'b1000};
        tv[6]  = '{2'b00, 1'b1, 1'b1, 16'h8080, 16'h1010, 16'h8080, 4'b1010};
        tv[7]  = '{2'b00, 1'b1, 1'b0, 16'h8080, 16'h1010, 16'h7070, 4'b1010};
        tv[8]  = '{2'b11, 1'b0, 1'b1, 16'h1234, 16'h4321, 16'h5555, 4'b0000};
        tv[9]  = '{2'b10, 1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b1000};
        tv[10] = '{2'b01, 1'b0, 1'b1, 16'h00FF, 16'h00FF, 16'h00FE, 4'b0000};
        tv[11] = '{2'b00, 1'b1, 1'b1, 16'h0000, 16'h8888, 16'h7777, 4'b1111};

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_ovfl", 32'(ovfl), 32'd0);
        chk("rst_sticky", 32'(sat_sticky), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            drive(tv[i]);
            in_valid = 1'b1;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_sum", i), 32'(sum), 32'(tv[i].s));
            chk($sformatf("v%0d_ovfl", i), 32'(ovfl), 32'(tv[i].o));
        end
        chk("sticky_accum", 32'(sat_sticky), 32'hF);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_no_load", 32'(sat_sticky), 32'd0);

        drive(tv[11]);
        in_valid = 1'b1;
        tick();
        chk("sticky_set", 32'(sat_sticky), 32'hF);
        drive(tv[4]);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_with_ovfl", 32'(sat_sticky), 32'b1000);
        drive(tv[3]);
        tick();
        chk("sticky_hold", 32'(sat_sticky), 32'b1000);
        in_valid = 1'b0;
        tick();

        drive(tv[3]);
        in_valid = 1'b1;
        tick();
        chk("bp_b1", 32'(sum), 32'h1335);
        drive(tv[8]);
        tick();
        chk("bp_b2", 32'(sum), 32'h5555);
        drive(tv[10]);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready0", 32'(in_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_sum", k), 32'(sum), 32'h5555);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_b3", 32'(sum), 32'h00FE);
        chk("bp_b3_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        drive(tv[0]);
        in_valid = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mid_loaded", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_ovfl", 32'(ovfl), 32'd0);
        chk("mid_rst_sticky", 32'(sat_sticky), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
